// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches from a 16-entry store at the PC address, issues the word to execute, then strobes the PC update.
// Latency: FETCH, ISSUE, WAIT_DONE, ADVANCE -- 4 cycles minimum per non-HALT instruction.
// Backpressure: instr_valid/instr_out hold while exec_ready is low; ADVANCE waits for exec_done seen in WAIT_DONE.
module fetch_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  instruction_addr,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               exec_ready,
    input  logic               exec_done,
    input  logic               branch_taken,
    output logic               PC_enable,
    output logic               jump,
    output logic [7:0]         jump_label,
    output logic [7:0]         pc_increment,
    output logic               busy,
    output logic               halted
);

    // Opcode field sits in the top nibble of the instruction word.
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_BRC  = 4'hD;
    localparam logic [3:0] OP_SKIP = 4'hC;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        ADVANCE   = 3'd4,
        HALT      = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    // Instruction store; deliberately not reset so a program survives rst_n.
    logic [INSTR_W-1:0] store [DEPTH];

    logic [INSTR_W-1:0] fetch_word;
    logic [3:0]         fetch_op;
    logic [3:0]         issued_op;
    logic [7:0]         issued_imm;
    logic               load_allowed;
    logic               done_seen;

    assign fetch_word   = store[instruction_addr];
    assign fetch_op     = fetch_word[INSTR_W-1 -: 4];
    assign issued_op    = instr_out[INSTR_W-1 -: 4];
    assign issued_imm   = instr_out[7:0];
    assign load_allowed = (state == IDLE) || (state == HALT);
    assign done_seen    = (state == WAIT_DONE) && exec_done;

    // Store write port, only open while the sequencer is parked.
    always_ff @(posedge clk) begin
        if (load_en && load_allowed) begin
            store[load_addr] <= load_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; exec_done only matters in WAIT_DONE, start only when parked.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                if (fetch_op == OP_HALT) state_nxt = HALT;
                else                     state_nxt = ISSUE;
            end
            ISSUE: begin
                if (exec_ready) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (exec_done) state_nxt = ADVANCE;
            end
            ADVANCE: begin
                state_nxt = FETCH;
            end
            HALT: begin
                if (start) state_nxt = FETCH;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State-decoded outputs; decoding straight from state makes them drop with the async reset.
    always_comb begin
        instr_valid = (state == ISSUE);
        PC_enable   = (state == ADVANCE);
        busy        = (state != IDLE) && (state != HALT);
        halted      = (state == HALT);
    end

    // Capture the fetched word; it stays stable through ISSUE and beyond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_out <= '0;
        end else if (state == FETCH) begin
            instr_out <= fetch_word;
        end
    end

    // Resolve PC controls when exec_done arrives so they are valid during ADVANCE and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump         <= 1'b0;
            jump_label   <= 8'h00;
            pc_increment <= 8'h00;
        end else if (done_seen) begin
            case (issued_op)
                OP_JMP: begin
                    jump         <= 1'b1;
                    jump_label   <= issued_imm;
                    pc_increment <= 8'h00;
                end
                OP_BRC: begin
                    jump         <= branch_taken;
                    jump_label   <= issued_imm;
                    pc_increment <= 8'h00;
                end
                OP_SKIP: begin
                    jump         <= 1'b0;
                    pc_increment <= issued_imm;
                end
                default: begin
                    jump         <= 1'b0;
                    pc_increment <= 8'h00;
                end
            endcase
        end
    end

endmodule
